// File: rtl/pcie_tx_tlp_arbiter_pkg.sv
// Shared definitions for the PCIe TX TLP arbiter.
//   TBUF_*      : bit positions inside trn_tbuf_av (core TX buffer credits)
//   arb_state_t : link ownership state of the arbiter
package pcie_tx_tlp_arbiter_pkg;

  localparam int unsigned TBUF_NP  = 0;  // non-posted
  localparam int unsigned TBUF_P   = 1;  // posted
  localparam int unsigned TBUF_CPL = 2;  // completion

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/pcie_tx_tlp_arbiter_rr_arbiter2.sv
// Combinational two-way pick between two eligible requesters.
//   elig0/elig1 : requester is allowed to take the link
//   last_owner  : requester that finished most recently (loses a tie in RR mode)
//   pick_valid  : at least one requester is eligible
//   pick        : winning requester index (0/1), meaningful when pick_valid
module pcie_tx_tlp_arbiter_rr_arbiter2 #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic elig0,
  input  logic elig1,
  input  logic last_owner,
  output logic pick_valid,
  output logic pick
);

  always_comb begin
    pick_valid = elig0 | elig1;
    pick       = 1'b0;
    if (elig0 && elig1) begin
      pick = (FIXED_PRIO != 0) ? 1'b1 : ~last_owner;
    end else if (elig1) begin
      pick = 1'b1;
    end
  end

endmodule

// File: rtl/pcie_tx_tlp_arbiter.sv
// Shares the 64-bit TRN TX local-link between two TLP sources:
// requester 0 (posted-write DMA engine) and requester 1 (completion engine).
// Grants are packet-atomic, round-robin or fixed priority, gated by core credits.
//   trn_*        : endpoint core TX port (clock, reset, link, muxed data, credits)
//   rN_req/gnt   : whole-TLP request / ownership of the link for requester N
//   rN_t*        : requester N local-link signals; dst_rdy/dsc routed to the owner
//   tlp_cnt0/1   : wrapping count of TLPs completed per requester
//   err_overlength : sticky, set when a TLP runs to MAX_BEATS beats without eof
module pcie_tx_tlp_arbiter
  import pcie_tx_tlp_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BEATS  = 36,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic             trn_clk,
  input  logic             trn_reset_n,
  input  logic             trn_lnk_up_n,
  output logic [63:0]      trn_td,
  output logic [7:0]       trn_trem_n,
  output logic             trn_tsof_n,
  output logic             trn_teof_n,
  output logic             trn_tsrc_rdy_n,
  input  logic             trn_tdst_rdy_n,
  input  logic             trn_tdst_dsc_n,
  input  logic [3:0]       trn_tbuf_av,
  input  logic             r0_req,
  output logic             r0_gnt,
  input  logic [63:0]      r0_td,
  input  logic [7:0]       r0_trem_n,
  input  logic             r0_tsof_n,
  input  logic             r0_teof_n,
  input  logic             r0_tsrc_rdy_n,
  output logic             r0_tdst_rdy_n,
  output logic             r0_tdst_dsc_n,
  input  logic             r1_req,
  output logic             r1_gnt,
  input  logic [63:0]      r1_td,
  input  logic [7:0]       r1_trem_n,
  input  logic             r1_tsof_n,
  input  logic             r1_teof_n,
  input  logic             r1_tsrc_rdy_n,
  output logic             r1_tdst_rdy_n,
  output logic             r1_tdst_dsc_n,
  output logic [CNT_W-1:0] tlp_cnt0,
  output logic [CNT_W-1:0] tlp_cnt1,
  output logic             err_overlength
);

  localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BEATS);

  arb_state_t        state;
  arb_state_t        grant_state;
  logic              last_owner;
  logic [BEAT_W-1:0] beat_cnt;
  logic              elig0;
  logic              elig1;
  logic              owner_idx;
  logic              arb_last;
  logic              pick_valid;
  logic              pick;
  logic              beat_acc;
  logic              eof_acc;
  logic              unused_tbuf;

  assign elig0       = r0_req & trn_tbuf_av[TBUF_P];
  assign elig1       = r1_req & trn_tbuf_av[TBUF_CPL];
  assign owner_idx   = (state == OWN1);
  assign unused_tbuf = trn_tbuf_av[TBUF_NP] ^ trn_tbuf_av[3];

  // While owning, the arbiter is only consulted on the eof beat, where the
  // current owner is about to become last_owner; feed that in directly so the
  // back-to-back re-grant sees the updated history without a bubble.
  assign arb_last    = (state == IDLE) ? last_owner : owner_idx;
  assign grant_state = pick ? OWN1 : OWN0;

  pcie_tx_tlp_arbiter_rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .elig0      (elig0),
    .elig1      (elig1),
    .last_owner (arb_last),
    .pick_valid (pick_valid),
    .pick       (pick)
  );

  always_comb begin
    trn_td         = '0;
    trn_trem_n     = '1;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    r0_gnt         = 1'b0;
    r1_gnt         = 1'b0;
    r0_tdst_rdy_n  = 1'b1;
    r1_tdst_rdy_n  = 1'b1;
    r0_tdst_dsc_n  = 1'b1;
    r1_tdst_dsc_n  = 1'b1;
    case (state)
      OWN0: begin
        trn_td         = r0_td;
        trn_trem_n     = r0_trem_n;
        trn_tsof_n     = r0_tsof_n;
        trn_teof_n     = r0_teof_n;
        trn_tsrc_rdy_n = r0_tsrc_rdy_n;
        r0_gnt         = 1'b1;
        r0_tdst_rdy_n  = trn_tdst_rdy_n;
        r0_tdst_dsc_n  = trn_tdst_dsc_n;
      end
      OWN1: begin
        trn_td         = r1_td;
        trn_trem_n     = r1_trem_n;
        trn_tsof_n     = r1_tsof_n;
        trn_teof_n     = r1_teof_n;
        trn_tsrc_rdy_n = r1_tsrc_rdy_n;
        r1_gnt         = 1'b1;
        r1_tdst_rdy_n  = trn_tdst_rdy_n;
        r1_tdst_dsc_n  = trn_tdst_dsc_n;
      end
      default: ;
    endcase
  end

  assign beat_acc = (state != IDLE) & ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n;
  assign eof_acc  = beat_acc & ~trn_teof_n;

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state          <= IDLE;
      last_owner     <= 1'b1;
      beat_cnt       <= '0;
      tlp_cnt0       <= '0;
      tlp_cnt1       <= '0;
      err_overlength <= 1'b0;
    end else if (trn_lnk_up_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= grant_state;
          end
        end
        OWN0, OWN1: begin
          if (!trn_tdst_dsc_n) begin
            state      <= IDLE;
            last_owner <= owner_idx;
            beat_cnt   <= '0;
          end else if (eof_acc) begin
            if (owner_idx) begin
              tlp_cnt1 <= tlp_cnt1 + CNT_W'(1);
            end else begin
              tlp_cnt0 <= tlp_cnt0 + CNT_W'(1);
            end
            last_owner <= owner_idx;
            beat_cnt   <= '0;
            state      <= pick_valid ? grant_state : IDLE;
          end else if (beat_acc) begin
            if (beat_cnt != BEAT_MAX) begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
            // This beat is the MAX_BEATS-th (or later) one and still not eof.
            if (beat_cnt >= BEAT_MAX - BEAT_W'(1)) begin
              err_overlength <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_tx_tlp_arbiter.sv
module tb_pcie_tx_tlp_arbiter;

  localparam int unsigned MAX_BEATS = 36;
  localparam int unsigned CNT_W     = 16;

  logic             trn_clk = 1'b0;
  logic             trn_reset_n;
  logic             trn_lnk_up_n;
  logic [63:0]      trn_td;
  logic [7:0]       trn_trem_n;
  logic             trn_tsof_n;
  logic             trn_teof_n;
  logic             trn_tsrc_rdy_n;
  logic             trn_tdst_rdy_n;
  logic             trn_tdst_dsc_n;
  logic [3:0]       trn_tbuf_av;
  logic             r0_req, r1_req;
  logic             r0_gnt, r1_gnt;
  logic [63:0]      r0_td, r1_td;
  logic [7:0]       r0_trem_n, r1_trem_n;
  logic             r0_tsof_n, r1_tsof_n;
  logic             r0_teof_n, r1_teof_n;
  logic             r0_tsrc_rdy_n, r1_tsrc_rdy_n;
  logic             r0_tdst_rdy_n, r1_tdst_rdy_n;
  logic             r0_tdst_dsc_n, r1_tdst_dsc_n;
  logic [CNT_W-1:0] tlp_cnt0, tlp_cnt1;
  logic             err_overlength;

  always #5 trn_clk = ~trn_clk;

  pcie_tx_tlp_arbiter #(
    .MAX_BEATS  (MAX_BEATS),
    .CNT_W      (CNT_W),
    .FIXED_PRIO (0)
  ) dut (
    .trn_clk        (trn_clk),
    .trn_reset_n    (trn_reset_n),
    .trn_lnk_up_n   (trn_lnk_up_n),
    .trn_td         (trn_td),
    .trn_trem_n     (trn_trem_n),
    .trn_tsof_n     (trn_tsof_n),
    .trn_teof_n     (trn_teof_n),
    .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
    .trn_tdst_rdy_n (trn_tdst_rdy_n),
    .trn_tdst_dsc_n (trn_tdst_dsc_n),
    .trn_tbuf_av    (trn_tbuf_av),
    .r0_req         (r0_req),
    .r0_gnt         (r0_gnt),
    .r0_td          (r0_td),
    .r0_trem_n      (r0_trem_n),
    .r0_tsof_n      (r0_tsof_n),
    .r0_teof_n      (r0_teof_n),
    .r0_tsrc_rdy_n  (r0_tsrc_rdy_n),
    .r0_tdst_rdy_n  (r0_tdst_rdy_n),
    .r0_tdst_dsc_n  (r0_tdst_dsc_n),
    .r1_req         (r1_req),
    .r1_gnt         (r1_gnt),
    .r1_td          (r1_td),
    .r1_trem_n      (r1_trem_n),
    .r1_tsof_n      (r1_tsof_n),
    .r1_teof_n      (r1_teof_n),
    .r1_tsrc_rdy_n  (r1_tsrc_rdy_n),
    .r1_tdst_rdy_n  (r1_tdst_rdy_n),
    .r1_tdst_dsc_n  (r1_tdst_dsc_n),
    .tlp_cnt0       (tlp_cnt0),
    .tlp_cnt1       (tlp_cnt1),
    .err_overlength (err_overlength)
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model: who should own the link, arbitration history, TLP
  // counts and the overlength flag, derived from the arbitration rules.
  int               exp_owner;   // -1 = nobody
  int               exp_last;
  int unsigned      exp_beats;
  logic [CNT_W-1:0] exp_cnt0, exp_cnt1;
  logic             exp_err;

  // Requester behaviour: queues of pending TLP lengths, current beat index.
  int unsigned q0[$];
  int unsigned q1[$];
  int unsigned bi[2];
  logic [63:0] drv_td[2];
  logic [7:0]  drv_trem[2];
  logic        drv_sof[2], drv_eof[2], drv_srdy[2], drv_req[2];

  // Knobs
  int unsigned rdy_mode, stall_pct, drop_pct;
  logic        rand_tbuf, dsc_on_beat2, record_order;

  // DUT observations
  int unsigned idle_src_cnt, dsc_seen;
  int unsigned sof_order[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int unsigned head_len(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic pop_job(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
    bi[i] = 0;
  endtask

  function automatic int pick(input logic e0, input logic e1, input int last);
    if (e0 && e1) return (last == 0) ? 1 : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      int unsigned qs;
      qs = qsize(i);
      // While owning, req means "another whole TLP is queued behind this one".
      drv_req[i] = (exp_owner == i) ? (qs > 1) : (qs > 0);
      if (drop_pct != 0 && $urandom_range(99) < drop_pct) drv_req[i] = 1'b0;
      if (exp_owner == i) begin
        drv_srdy[i] = ($urandom_range(99) < stall_pct);
        drv_sof[i]  = (bi[i] == 0) ? 1'b0 : 1'b1;
        drv_eof[i]  = (bi[i] == head_len(i) - 1) ? 1'b0 : 1'b1;
      end else begin
        drv_srdy[i] = 1'b1;
        drv_sof[i]  = 1'($urandom);
        drv_eof[i]  = 1'($urandom);
      end
      drv_td[i]   = {$urandom, $urandom};
      drv_trem[i] = 8'($urandom);
    end
    r0_req = drv_req[0]; r0_td = drv_td[0]; r0_trem_n = drv_trem[0];
    r0_tsof_n = drv_sof[0]; r0_teof_n = drv_eof[0]; r0_tsrc_rdy_n = drv_srdy[0];
    r1_req = drv_req[1]; r1_td = drv_td[1]; r1_trem_n = drv_trem[1];
    r1_tsof_n = drv_sof[1]; r1_teof_n = drv_eof[1]; r1_tsrc_rdy_n = drv_srdy[1];
    case (rdy_mode)
      0:       trn_tdst_rdy_n = 1'b0;
      1:       trn_tdst_rdy_n = ~trn_tdst_rdy_n;
      default: trn_tdst_rdy_n = 1'($urandom);
    endcase
    trn_tdst_dsc_n = 1'b1;
    if (dsc_on_beat2 && exp_owner == 1 && bi[1] == 1) begin
      trn_tdst_dsc_n = 1'b0;
      dsc_on_beat2   = 1'b0;
    end
    if (rand_tbuf) trn_tbuf_av = 4'($urandom);
  endtask

  task automatic check_outputs();
    int o;
    o = exp_owner;
    chk("r0_gnt", r0_gnt, o == 0);
    chk("r1_gnt", r1_gnt, o == 1);
    chk("trn_td",         trn_td,         (o < 0) ? 64'd0 : drv_td[o]);
    chk("trn_trem_n",     trn_trem_n,     (o < 0) ? 8'hFF : drv_trem[o]);
    chk("trn_tsof_n",     trn_tsof_n,     (o < 0) ? 1'b1 : drv_sof[o]);
    chk("trn_teof_n",     trn_teof_n,     (o < 0) ? 1'b1 : drv_eof[o]);
    chk("trn_tsrc_rdy_n", trn_tsrc_rdy_n, (o < 0) ? 1'b1 : drv_srdy[o]);
    chk("r0_tdst_rdy_n",  r0_tdst_rdy_n,  (o == 0) ? trn_tdst_rdy_n : 1'b1);
    chk("r1_tdst_rdy_n",  r1_tdst_rdy_n,  (o == 1) ? trn_tdst_rdy_n : 1'b1);
    chk("r0_tdst_dsc_n",  r0_tdst_dsc_n,  (o == 0) ? trn_tdst_dsc_n : 1'b1);
    chk("r1_tdst_dsc_n",  r1_tdst_dsc_n,  (o == 1) ? trn_tdst_dsc_n : 1'b1);
    chk("tlp_cnt0", tlp_cnt0, exp_cnt0);
    chk("tlp_cnt1", tlp_cnt1, exp_cnt1);
    chk("err_overlength", err_overlength, exp_err);
  endtask

  task automatic observe();
    if (trn_tsrc_rdy_n === 1'b1) idle_src_cnt++;
    if (r1_tdst_dsc_n === 1'b0) dsc_seen++;
    if (record_order && trn_tsof_n === 1'b0 && trn_tsrc_rdy_n === 1'b0 && trn_tdst_rdy_n === 1'b0)
      sof_order.push_back(r1_gnt ? 1 : 0);
  endtask

  task automatic model_step();
    logic e0, e1, acc;
    int   o, nxt;
    o  = exp_owner;
    e0 = drv_req[0] & trn_tbuf_av[1];
    e1 = drv_req[1] & trn_tbuf_av[2];
    nxt = o;
    if (trn_lnk_up_n) begin
      if (o >= 0) pop_job(o);
      nxt = -1;
      exp_beats = 0;
    end else if (o < 0) begin
      nxt = pick(e0, e1, exp_last);
    end else begin
      acc = !drv_srdy[o] && !trn_tdst_rdy_n;
      if (!trn_tdst_dsc_n) begin
        pop_job(o);
        exp_last = o; exp_beats = 0; nxt = -1;
      end else if (acc && !drv_eof[o]) begin
        if (o == 0) exp_cnt0 = exp_cnt0 + 1'b1;
        else        exp_cnt1 = exp_cnt1 + 1'b1;
        pop_job(o);
        exp_last = o; exp_beats = 0;
        nxt = pick(e0, e1, exp_last);
      end else if (acc) begin
        bi[o]++;
        if (exp_beats < MAX_BEATS) exp_beats++;
        if (exp_beats >= MAX_BEATS) exp_err = 1'b1;
      end
    end
    exp_owner = nxt;
  endtask

  task automatic cycle();
    drive();
    #1;
    check_outputs();
    observe();
    model_step();
    @(posedge trn_clk);
    @(negedge trn_clk);
  endtask

  task automatic run_cycles(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cycle();
  endtask

  task automatic run_until_idle(input int unsigned budget, input string tag);
    int unsigned n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_owner >= 0) && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, n < budget, 1'b1);
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_r0_gnt"}, r0_gnt, 1'b0);
    chk({p, "_r1_gnt"}, r1_gnt, 1'b0);
    chk({p, "_td"}, trn_td, 64'd0);
    chk({p, "_trem"}, trn_trem_n, 8'hFF);
    chk({p, "_nbits"}, {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, r0_tdst_rdy_n,
                        r1_tdst_rdy_n, r0_tdst_dsc_n, r1_tdst_dsc_n}, 7'h7F);
    chk({p, "_cnt0"}, tlp_cnt0, 16'd0);
    chk({p, "_cnt1"}, tlp_cnt1, 16'd0);
    chk({p, "_err"}, err_overlength, 1'b0);
  endtask

  task automatic model_reset();
    exp_owner = -1; exp_last = 1; exp_beats = 0;
    exp_cnt0 = '0; exp_cnt1 = '0; exp_err = 1'b0;
    q0.delete(); q1.delete();
    bi[0] = 0; bi[1] = 0;
  endtask

  initial begin
    logic [CNT_W-1:0] base0, base1;
    int first;

    model_reset();
    rdy_mode = 0; stall_pct = 0; drop_pct = 0;
    rand_tbuf = 1'b0; dsc_on_beat2 = 1'b0; record_order = 1'b0;
    idle_src_cnt = 0; dsc_seen = 0;
    trn_reset_n = 1'b0; trn_lnk_up_n = 1'b0; trn_tdst_rdy_n = 1'b0;
    trn_tdst_dsc_n = 1'b1; trn_tbuf_av = 4'b1111;
    r0_req = 1'b1; r1_req = 1'b1;
    r0_td = '1; r1_td = '1; r0_trem_n = '0; r1_trem_n = '0;
    r0_tsof_n = 1'b0; r1_tsof_n = 1'b0; r0_teof_n = 1'b0; r1_teof_n = 1'b0;
    r0_tsrc_rdy_n = 1'b0; r1_tsrc_rdy_n = 1'b0;
    @(negedge trn_clk);
    @(negedge trn_clk);
    check_reset_vals("reset");
    trn_reset_n = 1'b1;

    // Single 3-beat TLP from requester 0 with only posted credit.
    trn_tbuf_av = 4'b0010;
    q0.push_back(3);
    run_until_idle(20, "single_timeout");
    chk("single_cnt0", tlp_cnt0, 16'd1);

    // Contention: 4 TLPs each, all credits, core always ready.
    trn_tbuf_av = 4'b1111;
    base0 = exp_cnt0; base1 = exp_cnt1;
    for (int k = 0; k < 4; k++) begin
      q0.push_back($urandom_range(1, 6));
      q1.push_back($urandom_range(1, 6));
    end
    first = 1 - exp_last;
    idle_src_cnt = 0; record_order = 1'b1; sof_order.delete();
    run_until_idle(100, "contention_timeout");
    record_order = 1'b0;
    chk("contention_no_bubble", idle_src_cnt, 1);
    chk("contention_sofs", sof_order.size(), 8);
    for (int k = 0; k < sof_order.size(); k++)
      chk("contention_order", sof_order[k], (first + k) % 2);
    chk("contention_cnt0", tlp_cnt0, base0 + 16'd4);
    chk("contention_cnt1", tlp_cnt1, base1 + 16'd4);

    // Credit gating: completion credit absent, then restored mid-TLP.
    trn_tbuf_av = 4'b0010;
    base1 = exp_cnt1;
    for (int k = 0; k < 3; k++) q0.push_back(3);
    for (int k = 0; k < 2; k++) q1.push_back(2);
    run_cycles(6);
    chk("gate_cnt1_held", tlp_cnt1, base1);
    chk("gate_r1_not_granted", r1_gnt, 1'b0);
    trn_tbuf_av = 4'b0110;
    run_until_idle(100, "gate_timeout");
    chk("gate_cnt1_after", tlp_cnt1, base1 + 16'd2);

    // Discontinue on beat 2 of a 4-beat TLP from requester 1, toggling ready.
    trn_tbuf_av = 4'b1111;
    rdy_mode = 1;
    base1 = exp_cnt1;
    dsc_seen = 0;
    q1.push_back(4);
    dsc_on_beat2 = 1'b1;
    run_until_idle(50, "dsc_timeout");
    chk("dsc_pulse_count", dsc_seen, 1);
    chk("dsc_cnt1_held", tlp_cnt1, base1);
    rdy_mode = 0;

    // Overlength: 40 beats, flag from beat 36, all beats forwarded.
    base0 = exp_cnt0;
    q0.push_back(40);
    run_until_idle(100, "overlen_timeout");
    chk("overlen_err", err_overlength, 1'b1);
    chk("overlen_cnt0", tlp_cnt0, base0 + 16'd1);
    q1.push_back(2);
    run_until_idle(20, "overlen2_timeout");
    chk("overlen_sticky", err_overlength, 1'b1);

    // Link drop mid-TLP.
    base1 = exp_cnt1;
    q1.push_back(10);
    run_cycles(4);
    trn_lnk_up_n = 1'b1;
    cycle();
    chk("lnk_src_rdy_idle", trn_tsrc_rdy_n, 1'b1);
    chk("lnk_gnt_dropped", r1_gnt, 1'b0);
    chk("lnk_cnt1_kept", tlp_cnt1, base1);
    chk("lnk_err_kept", err_overlength, 1'b1);
    cycle();
    trn_lnk_up_n = 1'b0;
    run_cycles(2);

    // Randomised traffic: random credits, lengths, stalls, ready and req drops.
    rand_tbuf = 1'b1; rdy_mode = 2; stall_pct = 20; drop_pct = 10;
    for (int k = 0; k < 400; k++) begin
      if (q0.size() < 4 && $urandom_range(99) < 15) q0.push_back($urandom_range(1, 8));
      if (q1.size() < 4 && $urandom_range(99) < 15) q1.push_back($urandom_range(1, 8));
      cycle();
    end
    rand_tbuf = 1'b0; trn_tbuf_av = 4'b1111; drop_pct = 0; stall_pct = 10;
    run_until_idle(2000, "random_drain_timeout");
    stall_pct = 0; rdy_mode = 0;

    // Asynchronous reset in the middle of a packet.
    q0.push_back(6);
    run_cycles(3);
    chk("mid_pkt_owner", r0_gnt, 1'b1);
    #2;
    trn_reset_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    model_reset();
    @(negedge trn_clk);
    trn_reset_n = 1'b1;
    run_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_tx_tlp_arbiter.md
Name: pcie_tx_tlp_arbiter

Overview:
- Shares the single 64-bit TRN TX local-link of the PCIe endpoint between two TLP sources.
- Requester 0 is the posted-write engine (rx packet DMA to hugepages). Requester 1 is the completion engine (BAR read completions for MDIO/host register access).
- Grants are packet-atomic and round-robin (optionally strict priority), gated by core buffer credits (trn_tbuf_av).
- Sits between the TLP generators and the endpoint core TX port; also keeps per-requester TLP counters and a sticky overlength error.

Parameters:
- MAX_BEATS, 36, max 64-bit beats per TLP; exceeding it sets err_overlength.
- CNT_W, 16, width of per-requester TLP counters.
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 1 always wins when both eligible.

Ports:
- trn_clk  in  1  TRN clock; the only clock.
- trn_reset_n  in  1  reset, asynchronous assert, active-low.
- trn_lnk_up_n  in  1  link up, active-low; high forces IDLE.
- trn_td  out  64  muxed TX data.
- trn_trem_n  out  8  muxed remainder.
- trn_tsof_n  out  1  muxed start of frame.
- trn_teof_n  out  1  muxed end of frame.
- trn_tsrc_rdy_n  out  1  muxed source ready.
- trn_tdst_rdy_n  in  1  core ready.
- trn_tdst_dsc_n  in  1  core discontinue.
- trn_tbuf_av  in  4  core credits: [1] posted, [2] completion.
- rN_req  in  1  requester N has a whole TLP ready (N = 0,1).
- rN_gnt  out  1  requester N owns the link.
- rN_td  in  64  requester N data.
- rN_trem_n  in  8  requester N remainder.
- rN_tsof_n  in  1  requester N start of frame.
- rN_teof_n  in  1  requester N end of frame.
- rN_tsrc_rdy_n  in  1  requester N source ready.
- rN_tdst_rdy_n  out  1  core ready routed to the owner; 1 when not owner.
- rN_tdst_dsc_n  out  1  one-cycle discontinue pulse to the owner.
- tlp_cnt0  out  CNT_W  TLPs completed by requester 0, wrapping.
- tlp_cnt1  out  CNT_W  TLPs completed by requester 1, wrapping.
- err_overlength  out  1  sticky overlength flag; cleared only by reset.

Behaviour:
- Reset (trn_reset_n=0, async):
  - state IDLE, rN_gnt=0, last_owner=1 (so requester 0 wins the first tie).
  - All _n outputs = 1, trn_td=0, trn_trem_n=0xFF.
  - Counters = 0, err_overlength = 0.
- Eligibility:
  - elig0 = r0_req & trn_tbuf_av[1]
  - elig1 = r1_req & trn_tbuf_av[2]
- States: IDLE, OWN0, OWN1. The state and a beat counter are registered; the datapath mux is combinational on state.
- IDLE:
  - If trn_lnk_up_n=0 and any requester is eligible, pick a winner.
  - Round-robin: the requester that is not last_owner wins when both are eligible.
  - FIXED_PRIO=1: requester 1 wins when both are eligible.
  - Go to OWNx next cycle; rx_gnt asserts that cycle, giving 1-cycle grant latency.
- OWNx:
  - trn_* outputs = rx_* inputs.
  - rx_tdst_rdy_n = trn_tdst_rdy_n; the non-owner sees 1.
  - A beat is accepted when rx_tsrc_rdy_n=0 and trn_tdst_rdy_n=0; each accepted beat increments beat_cnt.
  - Accepted beat with rx_teof_n=0:
    - tlp_cntx increments, last_owner <= x, beat_cnt <= 0.
    - Re-arbitrate in the same cycle using IDLE rules, excluding no one.
    - Next state is OWNy if anyone is eligible, else IDLE. There is no bubble.
  - beat_cnt reaching MAX_BEATS without eof: set err_overlength, keep forwarding (no truncation).
  - trn_tdst_dsc_n=0:
    - Pulse rx_tdst_dsc_n=0 for one cycle.
    - Drop the grant; next state IDLE; tlp_cntx is not incremented; last_owner <= x.
- trn_lnk_up_n=1 in any state: next state IDLE, grants drop, beat_cnt cleared. Counters and error are kept.
- rN_req deasserting while granted is ignored; the grant holds until eof or discontinue.
- Credit loss mid-TLP does not preempt; credits are checked only at grant time.
- Counters wrap from 2^CNT_W-1 to 0.
- The beat counter is sized ceil(log2(MAX_BEATS+1)) and saturates at MAX_BEATS.

Decomposition:
- Shared package: tbuf_av bit indices (TBUF_NP=0, TBUF_P=1, TBUF_CPL=2) and the state encoding localparams (IDLE/OWN0/OWN1).
- One natural sub-module: rr_arbiter2, the combinational 2-way round-robin/fixed-priority pick from (elig0, elig1, last_owner, FIXED_PRIO).
- Counters and the mux stay in the top level.

Test Plan:
- Single TLP: r0_req with tbuf_av=4'b0010, 3-beat TLP, core always ready.
  - Expect: r0_gnt 1 cycle after req, 3 beats on trn_td unchanged, tlp_cnt0=1, return to IDLE.
- Contention: both requesting continuously with all credits, 4 TLPs each.
  - Expect: grants alternate 0,1,0,1…; no idle cycle between eof and the next sof; tlp_cnt0=tlp_cnt1=4.
- Credit gating: both requesting, tbuf_av[2]=0.
  - Expect: only requester 0 is granted; set tbuf_av[2]=1 and requester 1 is granted after the current eof.
- Backpressure: trn_tdst_dsc_n=0 on beat 2 of a 4-beat TLP from requester 1, with trn_tdst_rdy_n toggling every cycle.
  - Expect: r1_tdst_dsc_n low for exactly 1 cycle, grant drops, tlp_cnt1 unchanged.
- Overlength: 40-beat TLP with MAX_BEATS=36.
  - Expect: err_overlength=1 from beat 36, all 40 beats forwarded, flag sticky until reset.
- Link drop: trn_lnk_up_n=1 mid-TLP.
  - Expect: state IDLE next cycle, trn_tsrc_rdy_n=1, counters retained.
  - Then async reset mid-packet: all outputs at reset values immediately.
